// File: rtl/fetch_stage_if.sv
// ICache read port between the fetch stage (master) and the instruction cache (slave).
interface fetch_stage_if;
    logic [31:0] addr;
    logic        re;
    logic [31:0] dout;

    modport master (output addr, output re, input dout);
    modport slave  (input addr, input re, output dout);
endinterface

// File: rtl/fetch_stage.sv
// Stage-I fetch front end: PC register, ICache addressing, kill/squash bubbles, stall replay.
// Optional macro FETCH_KILL_COUNT_EN adds a saturating o_kill_count output.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_2000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               reset,
    fetch_stage_if.master      icache,
    input  logic               i_stall,
    input  logic [1:0]         i_pc_sel,
    input  logic [31:0]        i_alu_target,
    input  logic               i_inst_kill,
    output logic [31:0]        o_inst_I,
    output logic [31:0]        o_pc_I,
    output logic [31:0]        o_pc4_I,
`ifdef FETCH_KILL_COUNT_EN
    output logic [31:0]        o_kill_count,
`endif
    output logic               o_inst_valid_I
);

    typedef enum logic [1:0] {StBoot, StRun, StStall} state_t;

    localparam logic [1:0] PcSelAlu  = 2'b01;
    localparam logic [1:0] PcSelHold = 2'b10;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_valid;
    logic        r_squash;
    logic        r_redirect_pend;
    logic [31:0] r_redirect_pc;

    logic [31:0] w_target;
    logic [31:0] w_pc4;
    logic [31:0] w_next_pc;
    logic        w_stalled;
    logic        w_valid;

    assign w_target  = i_alu_target & ~32'h3;
    assign w_pc4     = r_pc + 32'd4;
    assign w_stalled = i_stall && (r_state != StBoot);
    assign w_valid   = r_valid && !r_squash && !i_inst_kill;

    // A squashed slot refetches its own PC so the redirect target is not skipped.
    always_comb begin
        w_next_pc = w_pc4;
        if (r_state == StBoot) begin
            w_next_pc = RESET_PC;
        end else if (r_redirect_pend) begin
            w_next_pc = r_redirect_pc;
        end else if (i_pc_sel == PcSelAlu) begin
            w_next_pc = w_target;
        end else if ((i_pc_sel == PcSelHold) || r_squash) begin
            w_next_pc = r_pc;
        end
    end

    assign icache.addr    = w_stalled ? r_pc : w_next_pc;
    assign icache.re      = 1'b1;
    assign o_pc_I         = r_pc;
    assign o_pc4_I        = w_pc4;
    assign o_inst_valid_I = w_valid;
    assign o_inst_I       = !w_valid            ? NOP_INST :
                            (r_state == StStall) ? r_inst   : icache.dout;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= StBoot;
            r_pc            <= RESET_PC - 32'd4;
            r_inst          <= NOP_INST;
            r_valid         <= 1'b0;
            r_squash        <= 1'b0;
            r_redirect_pend <= 1'b0;
            r_redirect_pc   <= 32'h0;
        end else begin
            case (r_state)
                StBoot: begin
                    r_state <= StRun;
                    r_pc    <= RESET_PC;
                    r_valid <= 1'b1;
                end
                default: begin
                    // Capture the instruction while the cache output is still fresh.
                    if (r_state == StRun) begin
                        r_inst <= icache.dout;
                    end
                    if (i_stall) begin
                        r_state <= StStall;
                        if ((i_pc_sel == PcSelAlu) || i_inst_kill) begin
                            r_redirect_pend <= 1'b1;
                            r_redirect_pc   <= w_target;
                        end
                    end else begin
                        r_state         <= StRun;
                        r_pc            <= w_next_pc;
                        r_squash        <= i_inst_kill;
                        r_redirect_pend <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef FETCH_KILL_COUNT_EN
    logic [31:0] r_kill_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_kill_count <= 32'h0;
        end else if (i_inst_kill && !i_stall && (r_kill_count != 32'hFFFF_FFFF)) begin
            r_kill_count <= r_kill_count + 32'd1;
        end
    end

    assign o_kill_count = r_kill_count;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a one-cycle-latency ICache model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  pc_sel;
    logic [31:0] alu_target;
    logic        inst_kill;
    logic [31:0] inst_I;
    logic [31:0] pc_I;
    logic [31:0] pc4_I;
    logic        inst_valid_I;
`ifdef FETCH_KILL_COUNT_EN
    logic [31:0] kill_count;
`endif

    int checks = 0;
    int errors = 0;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .icache         (bus.master),
        .i_stall        (stall),
        .i_pc_sel       (pc_sel),
        .i_alu_target   (alu_target),
        .i_inst_kill    (inst_kill),
        .o_inst_I       (inst_I),
        .o_pc_I         (pc_I),
        .o_pc4_I        (pc4_I),
`ifdef FETCH_KILL_COUNT_EN
        .o_kill_count   (kill_count),
`endif
        .o_inst_valid_I (inst_valid_I)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A00_0000;
    endfunction

    always @(posedge clk) bus.dout <= mem(bus.addr);

    localparam logic [31:0] Nop = 32'h0000_0013;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; pc_sel = 2'b00; alu_target = 32'h0; inst_kill = 1'b0;
        tick();
        tick();
        chk("rst_pc", pc_I, 32'h0000_1FFC);
        chk("rst_valid", {31'b0, inst_valid_I}, 32'h0);
        chk("rst_inst", inst_I, Nop);
        chk("rst_re", {31'b0, bus.re}, 32'h1);
`ifdef FETCH_KILL_COUNT_EN
        chk("rst_kcnt", kill_count, 32'h0);
`endif
        // Boot and sequential fetch
        reset = 1'b0;
        #1;
        chk("boot_addr", bus.addr, 32'h0000_2000);
        chk("boot_valid", {31'b0, inst_valid_I}, 32'h0);
        chk("boot_pc4", pc4_I, 32'h0000_2000);
        tick();
        chk("run1_pc", pc_I, 32'h0000_2000);
        chk("run1_inst", inst_I, mem(32'h0000_2000));
        chk("run1_valid", {31'b0, inst_valid_I}, 32'h1);
        chk("run1_addr", bus.addr, 32'h0000_2004);
        tick();
        chk("run2_addr", bus.addr, 32'h0000_2008);
        chk("run2_inst", inst_I, mem(32'h0000_2004));
        tick();
        // Taken jump with kill at pc 0x2008
        pc_sel = 2'b01; alu_target = 32'h0000_3000; inst_kill = 1'b1;
        #1;
        chk("kill_addr", bus.addr, 32'h0000_3000);
        chk("kill_inst", inst_I, Nop);
        chk("kill_valid", {31'b0, inst_valid_I}, 32'h0);
        tick();
        pc_sel = 2'b00; inst_kill = 1'b0;
        #1;
        chk("sq_valid", {31'b0, inst_valid_I}, 32'h0);
        chk("sq_inst", inst_I, Nop);
        chk("sq_addr", bus.addr, 32'h0000_3000);
        tick();
        chk("tgt_pc", pc_I, 32'h0000_3000);
        chk("tgt_inst", inst_I, mem(32'h0000_3000));
        chk("tgt_valid", {31'b0, inst_valid_I}, 32'h1);
        tick();
        tick();
        tick();
        tick();
        chk("pre_stall_pc", pc_I, 32'h0000_3010);
        // Three-cycle stall
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_addr", bus.addr, 32'h0000_3010);
            chk("stall_pc", pc_I, 32'h0000_3010);
            chk("stall_inst", inst_I, mem(32'h0000_3010));
            tick();
        end
        stall = 1'b0;
        #1;
        chk("unstall_addr", bus.addr, 32'h0000_3014);
        chk("unstall_inst", inst_I, mem(32'h0000_3010));
        tick();
        chk("post_stall_pc", pc_I, 32'h0000_3014);
        chk("post_stall_inst", inst_I, mem(32'h0000_3014));
        // Redirect pulsed mid-stall is replayed
        stall = 1'b1;
        tick();
        pc_sel = 2'b01; alu_target = 32'h0000_4000;
        #1;
        chk("rdstall_addr", bus.addr, 32'h0000_3014);
        tick();
        pc_sel = 2'b00; alu_target = 32'h0;
        tick();
        stall = 1'b0;
        #1;
        chk("replay_addr", bus.addr, 32'h0000_4000);
        chk("replay_pc", pc_I, 32'h0000_3014);
        tick();
        chk("replay_tpc", pc_I, 32'h0000_4000);
        chk("replay_tinst", inst_I, mem(32'h0000_4000));
        chk("replay_next", bus.addr, 32'h0000_4004);
        // Wraparound and target alignment
        pc_sel = 2'b01; alu_target = 32'hFFFF_FFFC;
        #1;
        chk("wrap_tgt", bus.addr, 32'hFFFF_FFFC);
        tick();
        pc_sel = 2'b00;
        #1;
        chk("wrap_addr", bus.addr, 32'h0000_0000);
        chk("wrap_pc4", pc4_I, 32'h0000_0000);
        tick();
        chk("wrap_pc", pc_I, 32'h0000_0000);
        chk("wrap_inst", inst_I, mem(32'h0000_0000));
        pc_sel = 2'b01; alu_target = 32'h0000_3002;
        #1;
        chk("align_addr", bus.addr, 32'h0000_3000);
        tick();
        pc_sel = 2'b10;
        #1;
        chk("hold_addr", bus.addr, 32'h0000_3000);
        tick();
        chk("hold_pc", pc_I, 32'h0000_3000);
        chk("hold_inst", inst_I, mem(32'h0000_3000));
        pc_sel = 2'b11;
        #1;
        chk("sel11_addr", bus.addr, 32'h0000_3004);
`ifdef FETCH_KILL_COUNT_EN
        chk("kcnt_one", kill_count, 32'h1);
`endif
        // Reset during stall with pending redirect
        pc_sel = 2'b00; stall = 1'b1;
        tick();
        pc_sel = 2'b01; alu_target = 32'h0000_5000;
        tick();
        pc_sel = 2'b00; reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("rs_addr", bus.addr, 32'h0000_2000);
        chk("rs_pc", pc_I, 32'h0000_1FFC);
        chk("rs_valid", {31'b0, inst_valid_I}, 32'h0);
`ifdef FETCH_KILL_COUNT_EN
        chk("rs_kcnt", kill_count, 32'h0);
`endif
        tick();
        stall = 1'b0;
        #1;
        chk("rs_run_pc", pc_I, 32'h0000_2000);
        chk("rs_run_addr", bus.addr, 32'h0000_2004);
        inst_kill = 1'b1;
        tick();
        tick();
        inst_kill = 1'b0;
`ifdef FETCH_KILL_COUNT_EN
        chk("kcnt_two", kill_count, 32'h2);
`endif
        chk("end_pc", pc_I, 32'h0000_2004);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
